// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// calc_pkg : shared types and constants for the calculator result path
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int CALC_NCH   = 4;

  // Channel numbering of the arithmetic units feeding the selector
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_hold_reg.sv
//------------------------------------------------------------------------------
// calc_hold_reg : load-enabled holding register with asynchronous clear
// Rev 1.0       : initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_hold_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_result_sel.sv
//------------------------------------------------------------------------------
// calc_result_sel : registered NCH-way result selector with valid/ready output.
// Optional transfer counter on out_cnt when CALC_SEL_CNT_EN is defined.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module calc_result_sel
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int NCH   = CALC_NCH,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [NCH-1:0]       ch_err,
  output logic [NCH-1:0]       ch_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_bad
`ifdef CALC_SEL_CNT_EN
  ,
  output logic [15:0]          out_cnt
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             sel_vld;
  logic             accept;
  logic             take;

  assign sel_bad = (32'(sel) >= NCH);

  // Gated by rst_n so that no channel handshake completes while reset is held
  assign accept = rst_n & en & ~sel_bad & ((state == IDLE) | out_ready);
  assign take   = accept & sel_vld;

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    sel_vld  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(sel) == i) begin
        sel_data = ch_data[i*WIDTH +: WIDTH];
        sel_err  = ch_err[i];
        sel_vld  = ch_valid[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ready
    assign ch_ready[g] = accept & (32'(sel) == g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready && !take) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);

  calc_hold_reg #(
    .W(WIDTH + 1)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (take),
    .d    ({sel_err, sel_data}),
    .q    ({out_err, out_data})
  );

`ifdef CALC_SEL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 16'h0001;
    end
  end
`endif

endmodule

`default_nettype wire
